load_store_unit: RTL and testbench

Initiator side of the processor's data-memory interface. Takes one load/store/pass-through operation at a time from the execute stage. Issues an aligned 64-bit request with byte enables to the data memory over a valid/ready request channel and a valid-only response channel. Returns sign/zero-extended load data, or the ALU result for non-memory ops, to writeback, and stalls the pipeline while an access is outstanding.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_mem_if.sv | 28 ++
 rtl/lsu_align.sv | 35 +++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 codes,
// and the access-size helpers used by both the FSM and the byte-lane logic.
package lsu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // Byte-lane mask for a 1/2/4/8-byte access, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory port of the load/store unit: valid/ready request channel plus
// a valid-only response channel.
interface lsu_mem_if;
  import lsu_pkg::*;

  // Request transfers on a cycle where mem_req_valid && mem_req_ready; once
  // valid is raised, all request fields hold until that cycle. The response
  // has no ready: mem_rsp_valid carries one doubleword for one cycle.
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_be;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: shifts store data and byte enables into position and
// extracts/extends load data from an aligned doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rsp_rdata_i,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [7:0]      req_be_o,
  output logic [XLEN-1:0] ld_data_o
);

  logic [5:0]      bit_shift;
  logic [XLEN-1:0] rsp_shifted;
  logic            is_signed;

  assign bit_shift   = {addr_lo_i, 3'b000};
  assign req_wdata_o = wdata_i << bit_shift;
  assign req_be_o    = size_mask(funct3_i[1:0]) << addr_lo_i;
  assign rsp_shifted = rsp_rdata_i >> bit_shift;
  assign is_signed   = funct3_i inside {LB, LH, LW, LD};

  always_comb begin
    ld_data_o = rsp_shifted;
    case (funct3_i[1:0])
      2'd0: ld_data_o = {{56{is_signed & rsp_shifted[7]}},  rsp_shifted[7:0]};
      2'd1: ld_data_o = {{48{is_signed & rsp_shifted[15]}}, rsp_shifted[15:0]};
      2'd2: ld_data_o = {{32{is_signed & rsp_shifted[31]}}, rsp_shifted[31:0]};
      default: ld_data_o = rsp_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one operation at a time from execute, aligned
// 64-bit request with byte enables, extended load data back to writeback.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_read,
  input  logic            ex_write,
  input  logic [2:0]      ex_funct3,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_rdata,
  output logic            wb_err,
  output logic            stall,
  lsu_mem_if.master       mem,
  output state_t          dbg_state
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wb_rdata_q, wb_rdata_d;
  logic            wb_err_q, wb_err_d;

  logic [XLEN-1:0] req_wdata;
  logic [7:0]      req_be;
  logic [XLEN-1:0] ld_data;
  logic            illegal;

  lsu_align u_align (
    .addr_lo_i   (addr_q[2:0]),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q),
    .rsp_rdata_i (mem.mem_rsp_rdata),
    .req_wdata_o (req_wdata),
    .req_be_o    (req_be),
    .ld_data_o   (ld_data)
  );

  // Classification of the incoming op; only meaningful when read or write is set.
  assign illegal = (ex_read && ex_write)
                || (ex_read  && !(ex_funct3 inside {LB, LH, LW, LD, LBU, LHU, LWU}))
                || (ex_write && !(ex_funct3 inside {SB, SH, SW, SD}))
                || misaligned(ex_funct3[1:0], ex_addr[2:0]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    wb_rdata_d = wb_rdata_q;
    wb_err_d   = wb_err_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          addr_d   = ex_addr;
          wdata_d  = ex_wdata;
          funct3_d = ex_funct3;
          we_d     = ex_write;
          if (!ex_read && !ex_write) begin
            state_d    = S_DONE;
            wb_rdata_d = ex_addr;
            wb_err_d   = 1'b0;
          end else if (illegal) begin
            state_d    = S_DONE;
            wb_rdata_d = '0;
            wb_err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          if (we_q) begin
            state_d    = S_DONE;
            wb_rdata_d = '0;
            wb_err_d   = 1'b0;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem.mem_rsp_valid) begin
          state_d    = S_DONE;
          wb_rdata_d = ld_data;
          wb_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wb_rdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      wb_rdata_q <= wb_rdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign ex_ready  = (state_q == S_IDLE);
  assign stall     = !ex_ready;
  assign wb_valid  = (state_q == S_DONE);
  assign wb_rdata  = wb_rdata_q;
  assign wb_err    = wb_err_q;
  assign dbg_state = state_q;

  // Request fields are forced to zero outside REQ so the bus is quiet when idle.
  assign mem.mem_req_valid = (state_q == S_REQ);
  assign mem.mem_req_we    = mem.mem_req_valid & we_q;
  assign mem.mem_req_addr  = mem.mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem.mem_req_wdata = mem.mem_req_valid ? req_wdata : '0;
  assign mem.mem_req_be    = mem.mem_req_valid ? req_be : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level
// reference model of the memory access rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic            ex_ready;
  logic [63:0]     ex_addr;
  logic [63:0]     ex_wdata;
  logic            ex_read;
  logic            ex_write;
  logic [2:0]      ex_funct3;
  logic            wb_valid;
  logic [63:0]     wb_rdata;
  logic            wb_err;
  logic            stall;
  state_t          dbg_state;

  int tests = 0;
  int fails = 0;

  lsu_mem_if mem_bus ();

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_read   (ex_read),
    .ex_write  (ex_write),
    .ex_funct3 (ex_funct3),
    .wb_valid  (wb_valid),
    .wb_rdata  (wb_rdata),
    .wb_err    (wb_err),
    .stall     (stall),
    .mem       (mem_bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation from accept to the cycle after its writeback pulse.
  // rdly: cycles mem_req_ready is held low; sdly: response delay after handshake.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int rdly, input int sdly, input logic [63:0] rsp);
    int          nb, idx, exp_lat, cyc, req_cnt, rsp_cnt, got_cyc;
    logic        is_mem, exp_err, hs, sent, done;
    logic [63:0] exp_rd, exp_addr, exp_wd, mask, val;
    logic [7:0]  exp_be;

    // reference model
    nb = 1 << f3[1:0];
    idx = int'(a[2:0]);
    is_mem = 1'b0; exp_err = 1'b0; exp_rd = '0; exp_lat = 1;
    exp_addr = '0; exp_wd = '0; exp_be = '0;
    if (!rd && !wr) exp_rd = a;
    else if (rd && wr) exp_err = 1'b1;
    else if (rd && f3 == 3'b111) exp_err = 1'b1;
    else if (wr && f3 > 3'd3) exp_err = 1'b1;
    else if (idx % nb != 0) exp_err = 1'b1;
    else begin
      is_mem = 1'b1;
      exp_addr = a & ~64'h7;
      exp_be = 8'(((1 << nb) - 1) << idx);
      exp_wd = wd << (8 * idx);
      if (wr) exp_lat = 2 + rdly;
      else begin
        exp_lat = 3 + rdly + sdly;
        mask = (nb == 8) ? ~64'h0 : ((64'h1 << (8 * nb)) - 64'h1);
        val = (rsp >> (8 * idx)) & mask;
        if (f3 < 3'd4 && nb < 8 && val[8 * nb - 1]) val = val | ~mask;
        exp_rd = val;
      end
    end

    chk("idle_ready", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_read = rd; ex_write = wr; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd;
    @(posedge clk); #1;
    ex_valid = 1'b0;

    cyc = 1; req_cnt = 0; rsp_cnt = 0; got_cyc = -1;
    hs = 1'b0; sent = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      chk("busy_ready", ex_ready, 1'b0);
      chk("busy_stall", stall, 1'b1);
      chk("req_unexpected", mem_bus.mem_req_valid && (!is_mem || hs), 1'b0);
      if (mem_bus.mem_req_valid && is_mem && !hs) begin
        chk("req_addr", mem_bus.mem_req_addr, exp_addr);
        chk("req_we", mem_bus.mem_req_we, wr);
        chk("req_be", mem_bus.mem_req_be, exp_be);
        if (wr) chk("req_wdata", mem_bus.mem_req_wdata, exp_wd);
      end
      mem_bus.mem_req_ready = 1'b0;
      mem_bus.mem_rsp_valid = 1'b0;
      if (wb_valid) begin
        got_cyc = cyc;
        done = 1'b1;
        chk("wb_rdata", wb_rdata, exp_rd);
        chk("wb_err", wb_err, exp_err);
      end else if (mem_bus.mem_req_valid && !hs) begin
        if (req_cnt == rdly) begin
          mem_bus.mem_req_ready = 1'b1;
          hs = 1'b1;
        end else begin
          // stray response while the request waits must be ignored
          mem_bus.mem_rsp_valid = 1'b1;
          mem_bus.mem_rsp_rdata = {$urandom, $urandom};
        end
        req_cnt++;
      end else if (hs && !wr && !sent) begin
        if (rsp_cnt == sdly) begin
          mem_bus.mem_rsp_valid = 1'b1;
          mem_bus.mem_rsp_rdata = rsp;
          sent = 1'b1;
        end else begin
          mem_bus.mem_rsp_rdata = {$urandom, $urandom};
        end
        rsp_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;

    chk("wb_seen", done, 1'b1);
    chk("latency", 64'(got_cyc), 64'(exp_lat));
    chk("wb_pulse_single", wb_valid, 1'b0);
    chk("ready_after", ex_ready, 1'b1);
    chk("wb_rdata_hold", wb_rdata, exp_rd);
    chk("wb_err_hold", wb_err, exp_err);
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [63:0] r_a;
    int          sel;

    rst_n = 1'b0;
    ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ex_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rdata", wb_rdata, 64'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    chk("rst_req_valid", mem_bus.mem_req_valid, 1'b0);
    chk("rst_req_be", mem_bus.mem_req_be, 8'h00);
    chk("rst_state", dbg_state, S_IDLE);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed steps
    run_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 0, 0, 64'h0);
    run_op(1'b0, 1'b1, SB, 64'h13, 64'hAB, 0, 0, 64'h0);
    run_op(1'b1, 1'b0, LB, 64'h05, 64'h0, 0, 3, 64'h0000_8000_0000_0000);
    run_op(1'b1, 1'b0, LBU, 64'h05, 64'h0, 0, 3, 64'h0000_8000_0000_0000);
    run_op(1'b1, 1'b0, LW, 64'h06, 64'h0, 0, 0, 64'h0);
    run_op(1'b1, 1'b0, LD, 64'h08, 64'h0, 0, 0, 64'hDEAD_BEEF_0123_4567);
    run_op(1'b0, 1'b1, SW, 64'h104, 64'hCAFE_F00D, 4, 0, 64'h0);
    run_op(1'b1, 1'b0, LH, 64'h2E, 64'h0, 4, 1, 64'h8421_0000_0000_0000);
    run_op(1'b1, 1'b1, LW, 64'h40, 64'h0, 0, 0, 64'h0);
    run_op(1'b1, 1'b0, 3'b111, 64'h40, 64'h0, 0, 0, 64'h0);
    run_op(1'b0, 1'b1, 3'b100, 64'h40, 64'h0, 0, 0, 64'h0);
    run_op(1'b1, 1'b0, LWU, 64'h44, 64'h0, 1, 2, 64'hF000_0000_0000_0000);

    // reset while waiting for the load response
    ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0; ex_funct3 = LD;
    ex_addr = 64'h8; ex_wdata = '0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_req_ready = 1'b0;
    chk("resp_stall", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ex_ready, 1'b1);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_wb_valid", wb_valid, 1'b0);
    chk("midrst_wb_rdata", wb_rdata, 64'h0);
    chk("midrst_wb_err", wb_err, 1'b0);
    chk("midrst_req_valid", mem_bus.mem_req_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rsp_rdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b0;
    repeat (3) begin
      chk("late_rsp_wb_valid", wb_valid, 1'b0);
      chk("late_rsp_ready", ex_ready, 1'b1);
      @(posedge clk); #1;
    end

    // randomized operations
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 19);
      r_rd = 1'b0; r_wr = 1'b0;
      if (sel == 0) begin r_rd = 1'b1; r_wr = 1'b1; end
      else if (sel < 3) begin r_rd = 1'b0; r_wr = 1'b0; end
      else if (sel < 11) r_rd = 1'b1;
      else r_wr = 1'b1;
      r_f3 = 3'($urandom_range(0, 7));
      r_a = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) r_a = r_a & ~64'((1 << r_f3[1:0]) - 1);
      run_op(r_rd, r_wr, r_f3, r_a, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
